alu_cok_dongulu: RTL and testbench
==================================

Name: alu_cok_dongulu

Overview:
- Parametrised, handshaked execution unit.
- Single-cycle integer ops: arithmetic, logic, shift, compare and branch-compare.
- Multi-cycle M-extension ops: multiply, divide and remainder, run on an iterative shift-add / restoring-divide datapath.
- Sits in the CPU core execute stage, between operand select and writeback.
- Stalls the pipeline via valid/ready while a multi-cycle op runs.

Parameters:
- DATA_WIDTH, 32, operand and result width; power of two, >= 8.
- OP_WIDTH, 5, operation select width.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from s2; derived localparam, not overridable.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the in-flight op.
- in_valid  input  1  operands and op present.
- in_ready  output  1  unit can accept an op this cycle.
- s1  input  DATA_WIDTH  operand 1.
- s2  input  DATA_WIDTH  operand 2.
- op  input  OP_WIDTH  operation code.
- out_valid  output  1  alu_out holds a result.
- out_ready  input  1  consumer takes the result.
- alu_out  output  DATA_WIDTH  registered result.
- busy  output  1  multi-cycle op in progress.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, alu_out=0, busy=0, all iteration registers=0.
- Op codes 0x00-0x0F, in order: ADD, SUB, OR, AND, XOR, SLL, SRL, SRA, SLT, SLTU, EQ, GE, LT, NE, LTU, GEU.
  - Compare ops return 1 or 0, zero-extended.
  - Shifts use s2[SHAMT_W-1:0].
- Op codes 0x10-0x17: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, with RISC-V semantics at DATA_WIDTH.
- Op codes 0x18-0x1F: result 0, single-cycle.
- Accept: a transfer occurs when in_valid && in_ready.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + accept of a single-cycle op -> DONE. Result is registered; out_valid=1 the next cycle (latency 1).
  - IDLE + accept of a mul op -> MUL. Operand magnitudes and sign flags are latched.
  - IDLE + accept of a div/rem op -> DIV. Operand magnitudes and sign flags are latched.
  - MUL/DIV: one bit per cycle; iteration counter runs DATA_WIDTH-1 down to 0, then -> DONE.
  - Mul/div latency: accept to out_valid = DATA_WIDTH+1 cycles.
  - DONE: out_valid=1, alu_out stable. On out_ready -> IDLE.
- in_ready = (state==IDLE). There is no accept in the same cycle as the DONE->IDLE handoff (zero bubble is not required).
- busy = (state==MUL || state==DIV).
- Multiply: computes a 2*DATA_WIDTH product on magnitudes, then negates the product if the latched signs differ.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
  - MULHSU treats s1 as signed and s2 as unsigned.
- Divide by zero, decided at accept, skips iteration and goes straight to DONE (latency 1):
  - DIV/DIVU quotient = all ones.
  - REM/REMU = s1.
- Signed overflow, DIV with s1=MIN and s2=-1, is a latency-1 shortcut:
  - quotient = MIN.
  - REM = 0.
- Sign fix-up for DIV/REM: quotient negated when signs differ; remainder takes the sign of the dividend.
- flush: any state -> IDLE next cycle. out_valid drops, the result is discarded and the counter clears. flush has priority over accept in the same cycle.
- rst_n asserted mid-op: immediate return to reset values.
- No output changes while in DONE until out_ready is seen.

Decomposition:
- Shared header sabit_veriler.vh, extended with:
  - DATA_WIDTH and ALU_CNTR (= OP_WIDTH) defines.
  - The 24 op-code defines.
  - FSM state encodings.
- Sub-module alu_muldiv_iter holds the iterative datapath.
  - Interface: start, is_div, signed flags, operands, done, hi/lo product, quotient, remainder.
  - The top level keeps the FSM, single-cycle ops, special-case shortcuts and output register.

Test Plan:
- ADD 0x7FFFFFFF+1 and SRA 0x80000000 by 4 -> 0x80000000 and 0xF8000000; each out_valid 1 cycle after accept.
- MULH -2 x 3 -> 0xFFFFFFFF; MUL -> 0xFFFFFFFA. out_valid exactly 33 cycles after accept; busy high 32 cycles; in_ready low meanwhile.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7. Divide-by-zero result valid after 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0, each 1 cycle.
- out_ready held low 5 cycles after a result: alu_out and out_valid stable; in_ready=0; accept resumes the cycle after out_ready.
- flush at iteration 10 of a DIVU, and rst_n pulse mid-MUL: next cycle state IDLE, out_valid=0, in_ready=1. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_cok_dongulu_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the alu_cok_dongulu execution unit.
package alu_cok_dongulu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_OR     = 5'h02;
  localparam logic [4:0] OP_AND    = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_EQ     = 5'h0A;
  localparam logic [4:0] OP_GE     = 5'h0B;
  localparam logic [4:0] OP_LT     = 5'h0C;
  localparam logic [4:0] OP_NE     = 5'h0D;
  localparam logic [4:0] OP_LTU    = 5'h0E;
  localparam logic [4:0] OP_GEU    = 5'h0F;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  function automatic logic is_mul_op(input logic [4:0] o);
    return o[4:2] == 3'b100;
  endfunction

  function automatic logic is_div_op(input logic [4:0] o);
    return o[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle on operand magnitudes.
// Results are combinational from the final step so the caller can register them on done.
module alu_muldiv_iter
  import alu_cok_dongulu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  is_div,
  input  logic                  a_signed,
  input  logic                  b_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  logic            running;
  logic [CW-1:0]   cnt;
  logic            div_mode;
  logic            neg_res;
  logic            neg_rem;
  logic [W-1:0]    d;
  logic [2*W-1:0]  p;

  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_nxt;
  logic [W:0]      div_sh, div_diff;
  logic            div_ge;
  logic [2*W-1:0]  div_nxt;
  logic [2*W-1:0]  p_nxt;
  logic [2*W-1:0]  prod_fix;

  assign a_neg = a_signed & a[W-1];
  assign b_neg = b_signed & b[W-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // Multiply: p = {acc, multiplier}; divide: p = {partial remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, p[2*W-1:W]} + {1'b0, (p[0] ? d : {W{1'b0}})};
  assign mul_nxt  = {mul_sum, p[W-1:1]};
  assign div_sh   = {p[2*W-1:W], p[W-1]};
  assign div_diff = div_sh - {1'b0, d};
  assign div_ge   = ~div_diff[W];
  assign div_nxt  = {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), p[W-2:0], div_ge};
  assign p_nxt    = div_mode ? div_nxt : mul_nxt;

  assign prod_fix  = neg_res ? (~p_nxt + 1'b1) : p_nxt;
  assign hi        = prod_fix[2*W-1:W];
  assign lo        = prod_fix[W-1:0];
  assign quotient  = neg_res ? (~p_nxt[W-1:0] + 1'b1) : p_nxt[W-1:0];
  assign remainder = neg_rem ? (~p_nxt[2*W-1:W] + 1'b1) : p_nxt[2*W-1:W];
  assign done      = running && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      cnt      <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      d        <= '0;
      p        <= '0;
    end else if (clear) begin
      running  <= 1'b0;
      cnt      <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      d        <= '0;
      p        <= '0;
    end else if (start) begin
      running  <= 1'b1;
      cnt      <= CW'(W - 1);
      div_mode <= is_div;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      d        <= is_div ? b_mag : a_mag;
      p        <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
    end else if (running) begin
      p <= p_nxt;
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_cok_dongulu.sv
// Handshaked execute-stage ALU: single-cycle integer ops plus iterative mul/div/rem.
// Divide-by-zero and signed overflow bypass the iterator and complete in one cycle.
module alu_cok_dongulu
  import alu_cok_dongulu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] s1,
  input  logic [DATA_WIDTH-1:0] s2,
  input  logic [OP_WIDTH-1:0]   op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  busy
);
  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  state_t       state, state_nxt;
  logic [W-1:0] alu_nxt;
  logic [4:0]   opc, op_q;
  logic         accept, mul_op, div_op;
  logic         div_zero, div_ovf;
  logic [W-1:0] special_res, single_res;
  logic [SHAMT_W-1:0] shamt;
  logic         a_signed, b_signed, iter_start, iter_done;
  logic [W-1:0] it_hi, it_lo, it_quo, it_rem;

  assign opc       = 5'(op);
  assign accept    = in_valid && (state == ST_IDLE);
  assign mul_op    = is_mul_op(opc);
  assign div_op    = is_div_op(opc);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL) || (state == ST_DIV);
  assign shamt     = s2[SHAMT_W-1:0];

  assign div_zero    = (s2 == '0);
  assign div_ovf     = !opc[0] && (s1 == MIN_VAL) && (&s2);
  assign special_res = div_zero ? (opc[1] ? s1 : '1) : (opc[1] ? '0 : MIN_VAL);

  // MULHSU: signed s1, unsigned s2; all other signed variants treat both as signed.
  assign a_signed = mul_op ? (opc != OP_MULHU) : !opc[0];
  assign b_signed = mul_op ? ((opc == OP_MUL) || (opc == OP_MULH)) : !opc[0];

  always_comb begin
    single_res = '0;
    case (opc)
      OP_ADD:  single_res = s1 + s2;
      OP_SUB:  single_res = s1 - s2;
      OP_OR:   single_res = s1 | s2;
      OP_AND:  single_res = s1 & s2;
      OP_XOR:  single_res = s1 ^ s2;
      OP_SLL:  single_res = s1 << shamt;
      OP_SRL:  single_res = s1 >> shamt;
      OP_SRA:  single_res = $signed(s1) >>> shamt;
      OP_SLT, OP_LT: single_res = {{(W-1){1'b0}}, ($signed(s1) < $signed(s2))};
      OP_SLTU, OP_LTU: single_res = {{(W-1){1'b0}}, (s1 < s2)};
      OP_EQ:   single_res = {{(W-1){1'b0}}, (s1 == s2)};
      OP_NE:   single_res = {{(W-1){1'b0}}, (s1 != s2)};
      OP_GE:   single_res = {{(W-1){1'b0}}, ($signed(s1) >= $signed(s2))};
      OP_GEU:  single_res = {{(W-1){1'b0}}, (s1 >= s2)};
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    alu_nxt    = alu_out;
    iter_start = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        if (mul_op) begin
          state_nxt  = ST_MUL;
          iter_start = 1'b1;
        end else if (div_op && (div_zero || div_ovf)) begin
          state_nxt = ST_DONE;
          alu_nxt   = special_res;
        end else if (div_op) begin
          state_nxt  = ST_DIV;
          iter_start = 1'b1;
        end else begin
          state_nxt = ST_DONE;
          alu_nxt   = single_res;
        end
      end
      ST_MUL: if (iter_done) begin
        state_nxt = ST_DONE;
        alu_nxt   = (op_q == OP_MUL) ? it_lo : it_hi;
      end
      ST_DIV: if (iter_done) begin
        state_nxt = ST_DONE;
        alu_nxt   = op_q[1] ? it_rem : it_quo;
      end
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt  = ST_IDLE;
      alu_nxt    = alu_out;
      iter_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      alu_out <= '0;
      op_q    <= '0;
    end else begin
      state   <= state_nxt;
      alu_out <= alu_nxt;
      if (accept && !flush) op_q <= opc;
    end
  end

  alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .start     (iter_start),
    .is_div    (div_op),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .a         (s1),
    .b         (s2),
    .done      (iter_done),
    .hi        (it_hi),
    .lo        (it_lo),
    .quotient  (it_quo),
    .remainder (it_rem)
  );

endmodule

// File: tb/tb_alu_cok_dongulu.sv
// Self-checking bench for alu_cok_dongulu: scoreboard of expected results and latencies.
module tb_alu_cok_dongulu;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [31:0] s1, s2, alu_out;
  logic [4:0]  op;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] obs_res;
  int          obs_lat, obs_busy, obs_irh;

  localparam logic [31:0] MINV = 32'h8000_0000;

  alu_cok_dongulu #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .s1(s1), .s2(s2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pr;
    logic [63:0] pu;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a | b;
      5'h03: return a & b;
      5'h04: return a ^ b;
      5'h05: return a << b[4:0];
      5'h06: return a >> b[4:0];
      5'h07: return $signed(a) >>> b[4:0];
      5'h08, 5'h0C: return {31'b0, ia < ib};
      5'h09, 5'h0E: return {31'b0, a < b};
      5'h0A: return {31'b0, a == b};
      5'h0B: return {31'b0, ia >= ib};
      5'h0D: return {31'b0, a != b};
      5'h0F: return {31'b0, a >= b};
      5'h10: begin pr = sa * sb; return pr[31:0]; end
      5'h11: begin pr = sa * sb; return pr[63:32]; end
      5'h12: begin pr = sa * longint'({32'b0, b}); return pr[63:32]; end
      5'h13: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      5'h14: if (b == 0) return 32'hFFFF_FFFF; else if (a == MINV && b == 32'hFFFF_FFFF) return MINV; else return ia / ib;
      5'h15: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      5'h16: if (b == 0) return a; else if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0; else return ia % ib;
      5'h17: if (b == 0) return a; else return a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o >= 5'h10 && o <= 5'h13) return 33;
    if (o >= 5'h14 && o <= 5'h17) begin
      if (b == 0) return 1;
      if (!o[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Stimulus only: pushes expectations, drives one op and waits (bounded) for out_valid.
  task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input int el);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      nchk++; nerr++;
      $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
    end
    exp_q.push_back(e);
    lat_q.push_back(el);
    op = o; s1 = a; s2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs_lat = 1; obs_busy = 0; obs_irh = 0;
    while (!out_valid && obs_lat < 100) begin
      if (busy) obs_busy++;
      if (in_ready) obs_irh++;
      @(posedge clk); #1;
      obs_lat++;
    end
    obs_res = alu_out;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s1 = '0; s2 = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %0b want 0", busy); end
    nchk++; if (alu_out !== 32'h0) begin nerr++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [4:0]  ops[6] = '{5'h00, 5'h07, 5'h01, 5'h09, 5'h0B, 5'h05};
    logic [31:0] as[6]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
    logic [31:0] bs[6]  = '{32'h1, 32'h4, 32'h9, 32'h1, 32'h1, 32'h23};
    logic [31:0] fix[2] = '{32'h8000_0000, 32'hF800_0000};
    logic [31:0] e;
    int l;
    for (int i = 0; i < 6; i++) begin
      send(ops[i], as[i], bs[i], (i < 2) ? fix[i] : model(ops[i], as[i], bs[i]), 1);
      take();
      e = exp_q.pop_front(); l = lat_q.pop_front();
      nchk++; if (obs_res !== e) begin nerr++; $display("FAIL single_res[%0d] op=%h: got %h want %h", i, ops[i], obs_res, e); end
      nchk++; if (obs_lat !== l) begin nerr++; $display("FAIL single_lat[%0d]: got %0d want %0d", i, obs_lat, l); end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  ops[2] = '{5'h11, 5'h10};
    logic [31:0] want[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA};
    logic [31:0] e;
    int l;
    for (int i = 0; i < 2; i++) begin
      send(ops[i], 32'hFFFF_FFFE, 32'h3, want[i], 33);
      e = exp_q.pop_front(); l = lat_q.pop_front();
      nchk++; if (obs_res !== e) begin nerr++; $display("FAIL mul_res[%0d]: got %h want %h", i, obs_res, e); end
      nchk++; if (obs_lat !== l) begin nerr++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, obs_lat, l); end
      nchk++; if (obs_busy !== 32) begin nerr++; $display("FAIL mul_busy_cycles[%0d]: got %0d want 32", i, obs_busy); end
      nchk++; if (obs_irh !== 0) begin nerr++; $display("FAIL mul_in_ready_while_busy[%0d]: got %0d want 0", i, obs_irh); end
      take();
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops[6]  = '{5'h14, 5'h16, 5'h15, 5'h17, 5'h14, 5'h16};
    logic [31:0] as[6]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h7, 32'h7, MINV, MINV};
    logic [31:0] bs[6]   = '{32'h2, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, MINV, 32'h0};
    int          lats[6] = '{33, 33, 1, 1, 1, 1};
    logic [31:0] e;
    int l;
    for (int i = 0; i < 6; i++) begin
      send(ops[i], as[i], bs[i], want[i], lats[i]);
      take();
      e = exp_q.pop_front(); l = lat_q.pop_front();
      nchk++; if (obs_res !== e) begin nerr++; $display("FAIL div_res[%0d] op=%h: got %h want %h", i, ops[i], obs_res, e); end
      nchk++; if (obs_lat !== l) begin nerr++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, obs_lat, l); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    int l, bad;
    send(5'h04, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F, 1);
    e = exp_q.pop_front(); l = lat_q.pop_front();
    bad = 0;
    in_valid = 1'b1; op = 5'h00; s1 = 32'h1; s2 = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || alu_out !== e || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    nchk++; if (bad !== 0) begin nerr++; $display("FAIL hold_stable: unstable cycles %0d want 0 (alu_out=%h want %h)", bad, alu_out, e); end
    take();
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL resume_in_ready: got %0b want 1", in_ready); end
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL resume_out_valid: got %0b want 0", out_valid); end
  endtask

  task automatic check_idle(input string tag);
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s: out_valid=%0b in_ready=%0b busy=%0b want 0/1/0", tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic follow_add(input string tag);
    logic [31:0] e;
    int l;
    send(5'h00, 32'd2, 32'd3, 32'd5, 1);
    take();
    e = exp_q.pop_front(); l = lat_q.pop_front();
    nchk++; if (obs_res !== e || obs_lat !== l) begin nerr++; $display("FAIL %s: got %h lat %0d want %h lat %0d", tag, obs_res, obs_lat, e, l); end
  endtask

  task automatic test_flush();
    int stale = 0;
    op = 5'h15; s1 = 32'd1000; s2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_idle("flush_mid_divu");
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (out_valid) stale++; end
    nchk++; if (stale !== 0) begin nerr++; $display("FAIL flush_stale_result: got %0d valid cycles want 0", stale); end
    follow_add("flush_follow_add");
    op = 5'h00; s1 = 32'd1; s2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_idle("flush_beats_accept");
  endtask

  task automatic test_reset_mid();
    op = 5'h13; s1 = 32'hFFFF_FFFF; s2 = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("reset_mid_mul");
    nchk++; if (alu_out !== 32'h0) begin nerr++; $display("FAIL reset_mid_alu_out: got %h want 0", alu_out); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_mid_after");
    follow_add("reset_follow_add");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  o;
    logic [31:0] a, b, e;
    int l;
    for (int i = 0; i < 24; i++) begin
      o = 5'($urandom_range(0, 31));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
      send(o, a, b, model(o, a, b), model_lat(o, a, b));
      take();
      e = exp_q.pop_front(); l = lat_q.pop_front();
      nchk++; if (obs_res !== e) begin nerr++; $display("FAIL b2b_res[%0d] op=%h a=%h b=%h: got %h want %h", i, o, a, b, obs_res, e); end
      nchk++; if (obs_lat !== l) begin nerr++; $display("FAIL b2b_lat[%0d] op=%h: got %0d want %0d", i, o, obs_lat, l); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
